// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache way-selection blocks.
//   buf_state_e          : occupancy of the two-entry result buffer
//   DEFAULT_NUMBER_WAYS  : default associativity used by the way blocks
//   index_width()        : width of an encoded way index for a given way count
//   DEFAULT_INDEX_WIDTH  : index width that goes with DEFAULT_NUMBER_WAYS
// ----------------------------------------------------------------------------
package cache_pkg;

   // Occupancy of the main + skid result registers
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   localparam int DEFAULT_NUMBER_WAYS = 8;

   // Encoded way index width; a single-way cache would still need one bit
   function automatic int index_width(input int number_ways);
      return (number_ways > 1) ? $clog2(number_ways) : 1;
   endfunction

   localparam int DEFAULT_INDEX_WIDTH = index_width(DEFAULT_NUMBER_WAYS);

endpackage

// File: rtl/way_priority_encoder.sv
// ----------------------------------------------------------------------------
// way_priority_encoder
// Combinational priority encoder over a per-way hit vector. The highest-index
// set bit wins. An all-zero vector yields index 0, hit 0, multi_hit 0.
// Ports:
//   sel_in        [NUMBER_WAYS-1:0] per-way hit vector
//   index_out     [INDEX_WIDTH-1:0] encoded winning way
//   hit_out                         any bit of sel_in set
//   multi_hit_out                   two or more bits of sel_in set
// ----------------------------------------------------------------------------
module way_priority_encoder
   import cache_pkg::*;
#(
   parameter  int NUMBER_WAYS = DEFAULT_NUMBER_WAYS,
   localparam int INDEX_WIDTH = index_width(NUMBER_WAYS)
) (
   input  logic [NUMBER_WAYS-1:0] sel_in,
   output logic [INDEX_WIDTH-1:0] index_out,
   output logic                   hit_out,
   output logic                   multi_hit_out
);

   // Scan upward so a later (higher) set bit overwrites the index; a set bit
   // seen while hit is already set means at least two ways matched.
   always_comb begin
      index_out     = '0;
      hit_out       = 1'b0;
      multi_hit_out = 1'b0;
      for (int k = 0; k < NUMBER_WAYS; k++) begin
         if (sel_in[k]) begin
            multi_hit_out = multi_hit_out | hit_out;
            hit_out       = 1'b1;
            index_out     = INDEX_WIDTH'(k);
         end
      end
   end

endmodule

// File: rtl/way_select_pipe.sv
// ----------------------------------------------------------------------------
// way_select_pipe
// Selects one element out of a packed set of cache ways using a priority-
// encoded hit vector, and delivers the result through a two-entry skid buffer
// with valid/ready handshakes on both sides (latency 1).
// Ports:
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   way_packed_in     all way elements, way k at [(k+1)*W-1 : k*W]
//   sel_in            per-way hit vector
//   valid_in          qualifies way_packed_in / sel_in
//   ready_out         block accepts input this cycle (registered)
//   way_packed_out    selected element (0 when no hit)
//   way_index_out     encoded selected way
//   hit_out           any sel_in bit was set
//   multi_hit_out     two or more sel_in bits were set
//   valid_out         qualifies all result outputs (outputs read 0 otherwise)
//   ready_in          downstream acceptance
// ----------------------------------------------------------------------------
module way_select_pipe
   import cache_pkg::*;
#(
   parameter  int NUMBER_WAYS                 = DEFAULT_NUMBER_WAYS,
   parameter  int SINGLE_ELEMENT_SIZE_IN_BITS = 4,
   localparam int INDEX_WIDTH                 = index_width(NUMBER_WAYS)
) (
   input  logic                                              clk_in,
   input  logic                                              rst_n_in,
   input  logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0] way_packed_in,
   input  logic [NUMBER_WAYS-1:0]                            sel_in,
   input  logic                                              valid_in,
   output logic                                              ready_out,
   output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]            way_packed_out,
   output logic [INDEX_WIDTH-1:0]                            way_index_out,
   output logic                                              hit_out,
   output logic                                              multi_hit_out,
   output logic                                              valid_out,
   input  logic                                              ready_in
);

   localparam int W            = SINGLE_ELEMENT_SIZE_IN_BITS;
   localparam int RESULT_WIDTH = W + INDEX_WIDTH + 2;

   logic [INDEX_WIDTH-1:0]  enc_index;
   logic                    enc_hit;
   logic                    enc_multi;
   logic [W-1:0]            sel_data;
   logic [RESULT_WIDTH-1:0] new_result;
   logic [RESULT_WIDTH-1:0] main_result;
   logic [RESULT_WIDTH-1:0] skid_result;
   logic [RESULT_WIDTH-1:0] out_result;

   buf_state_e state_q;
   buf_state_e state_d;
   logic       ready_q;
   logic       in_xfer;
   logic       out_xfer;
   logic       load_main_new;
   logic       load_main_skid;
   logic       load_skid;

   way_priority_encoder #(
      .NUMBER_WAYS (NUMBER_WAYS)
   ) u_encoder (
      .sel_in        (sel_in),
      .index_out     (enc_index),
      .hit_out       (enc_hit),
      .multi_hit_out (enc_multi)
   );

   // Pick the element of the winning way. Without a hit nothing matches and
   // the data stays zero even though the encoded index is also zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUMBER_WAYS; k++) begin
         if (enc_hit && (enc_index == INDEX_WIDTH'(k))) begin
            sel_data = way_packed_in[k*W +: W];
         end
      end
   end

   assign new_result = {sel_data, enc_index, enc_hit, enc_multi};

   assign in_xfer   = valid_in & ready_q;
   assign valid_out = (state_q != BUF_EMPTY);
   assign out_xfer  = valid_out & ready_in;
   assign ready_out = ready_q;

   // Buffer occupancy register. Reset empties the buffer immediately, which
   // also drops valid_out without waiting for a clock.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= BUF_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next occupancy plus which register loads what. The oldest entry always
   // lives in main; skid only ever holds the younger of two entries, and
   // moves into main when main is consumed.
   always_comb begin
      state_d        = state_q;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         BUF_EMPTY: begin
            if (in_xfer) begin
               state_d       = BUF_ONE;
               load_main_new = 1'b1;
            end
         end
         BUF_ONE: begin
            if (in_xfer && out_xfer) begin
               load_main_new = 1'b1;
            end else if (in_xfer) begin
               state_d   = BUF_TWO;
               load_skid = 1'b1;
            end else if (out_xfer) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_TWO: begin
            if (out_xfer) begin
               state_d        = BUF_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: begin
            state_d = BUF_EMPTY;
         end
      endcase
   end

   // ready_out is a flop fed from the next occupancy, so there is no
   // combinational path from ready_in to ready_out. It is held low in reset
   // and rises on the first edge after release.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= (state_d != BUF_TWO);
      end
   end

   // Result storage. Entries only change on a load, so a stalled output holds
   // steady; reset clears both entries so nothing stale can resurface.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         main_result <= '0;
         skid_result <= '0;
      end else begin
         if (load_main_new) begin
            main_result <= new_result;
         end else if (load_main_skid) begin
            main_result <= skid_result;
         end
         if (load_skid) begin
            skid_result <= new_result;
         end
      end
   end

   assign out_result = valid_out ? main_result : '0;
   assign {way_packed_out, way_index_out, hit_out, multi_hit_out} = out_result;

endmodule

// File: tb/tb_way_select_pipe.sv
// ----------------------------------------------------------------------------
// tb_way_select_pipe
// Two instances share clock and reset: lane A uses the default 8 ways x 4 bits,
// lane B uses 5 ways x 32 bits. The driver pushes the expected result of every
// accepted input into a per-lane queue; a monitor on the falling edge compares
// the presented output against the queue head and pops on an output transfer.
// ----------------------------------------------------------------------------
module tb_way_select_pipe;
   import cache_pkg::*;

   localparam int A_WAYS = DEFAULT_NUMBER_WAYS;
   localparam int A_W    = 4;
   localparam int A_IW   = DEFAULT_INDEX_WIDTH;
   localparam int B_WAYS = 5;
   localparam int B_W    = 32;
   localparam int B_IW   = index_width(B_WAYS);

   typedef struct packed {
      logic [31:0] data;
      logic [5:0]  index;
      logic        hit;
      logic        multi;
   } result_t;

   logic clk;
   logic rst_n;

   logic [A_W*A_WAYS-1:0] a_way_in;
   logic [A_WAYS-1:0]     a_sel;
   logic                  a_valid_in;
   logic                  a_ready_out;
   logic [A_W-1:0]        a_way_out;
   logic [A_IW-1:0]       a_index;
   logic                  a_hit;
   logic                  a_multi;
   logic                  a_valid_out;
   logic                  a_ready_in;

   logic [B_W*B_WAYS-1:0] b_way_in;
   logic [B_WAYS-1:0]     b_sel;
   logic                  b_valid_in;
   logic                  b_ready_out;
   logic [B_W-1:0]        b_way_out;
   logic [B_IW-1:0]       b_index;
   logic                  b_hit;
   logic                  b_multi;
   logic                  b_valid_out;
   logic                  b_ready_in;

   result_t qa[$];
   result_t qb[$];
   logic    acc_a;
   logic    acc_b;
   logic    post_reset;
   logic    done;
   logic    stall_timeout;
   int      vectors;
   int      miscompares;

   way_select_pipe #(
      .NUMBER_WAYS                 (A_WAYS),
      .SINGLE_ELEMENT_SIZE_IN_BITS (A_W)
   ) dut_a (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .way_packed_in  (a_way_in),
      .sel_in         (a_sel),
      .valid_in       (a_valid_in),
      .ready_out      (a_ready_out),
      .way_packed_out (a_way_out),
      .way_index_out  (a_index),
      .hit_out        (a_hit),
      .multi_hit_out  (a_multi),
      .valid_out      (a_valid_out),
      .ready_in       (a_ready_in)
   );

   way_select_pipe #(
      .NUMBER_WAYS                 (B_WAYS),
      .SINGLE_ELEMENT_SIZE_IN_BITS (B_W)
   ) dut_b (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .way_packed_in  (b_way_in),
      .sel_in         (b_sel),
      .valid_in       (b_valid_in),
      .ready_out      (b_ready_out),
      .way_packed_out (b_way_out),
      .way_index_out  (b_index),
      .hit_out        (b_hit),
      .multi_hit_out  (b_multi),
      .valid_out      (b_valid_out),
      .ready_in       (b_ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: scan from the top way downwards, the first set bit wins;
   // count set bits for hit / multi-hit. No hit leaves everything zero.
   function automatic result_t refModel(input int ways, input int width,
                                        input logic [63:0] sel, input logic [255:0] data);
      result_t      r;
      int           found;
      logic [255:0] shifted;
      logic [31:0]  mask;
      r     = '0;
      found = 0;
      mask  = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      for (int k = ways - 1; k >= 0; k--) begin
         if (sel[k]) begin
            if (found == 0) begin
               shifted = data >> (k * width);
               r.data  = shifted[31:0] & mask;
               r.index = 6'(k);
            end
            found++;
         end
      end
      r.hit   = (found >= 1);
      r.multi = (found >= 2);
      return r;
   endfunction

   // Mix of empty, one-hot and arbitrary hit vectors
   function automatic logic [63:0] randSel(input int ways);
      logic [63:0] s;
      case ($urandom_range(0, 3))
         0:       s = 64'd0;
         1:       s = 64'd1 << $urandom_range(0, ways - 1);
         default: s = {$urandom(), $urandom()};
      endcase
      return s & ((64'd1 << ways) - 64'd1);
   endfunction

   task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
      end
   endtask

   // Drive one cycle of inputs on both lanes; record and model accepted inputs
   task automatic applyStimulus(input logic va, input logic [7:0] sa, input logic [31:0] da, input logic ra,
                                input logic vb, input logic [4:0] sb, input logic [159:0] db, input logic rb,
                                output logic got_a, output logic got_b);
      @(posedge clk);
      #1;
      a_valid_in = va;
      a_sel      = sa;
      a_way_in   = da;
      a_ready_in = ra;
      b_valid_in = vb;
      b_sel      = sb;
      b_way_in   = db;
      b_ready_in = rb;
      acc_a = va && a_ready_out;
      acc_b = vb && b_ready_out;
      if (acc_a) qa.push_back(refModel(A_WAYS, A_W, 64'(sa), 256'(da)));
      if (acc_b) qb.push_back(refModel(B_WAYS, B_W, 64'(sb), 256'(db)));
      got_a = acc_a;
      got_b = acc_b;
   endtask

   task automatic doReset(input int cycles);
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
      acc_a      = 1'b0;
      acc_b      = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Per-lane check of what the DUT presents this cycle against the queue.
   // Entries accepted at the coming edge are not in the DUT yet, so they are
   // excluded from the occupancy.
   task automatic checkOutput(input int lane);
      result_t exp_r;
      result_t act;
      int      held;
      logic    v;
      logic    r;
      logic    ri;
      string   tag;
      exp_r = '0;
      act   = '0;
      if (lane == 0) begin
         tag       = "A";
         v         = a_valid_out;
         r         = a_ready_out;
         ri        = a_ready_in;
         act.data  = 32'(a_way_out);
         act.index = 6'(a_index);
         act.hit   = a_hit;
         act.multi = a_multi;
         held      = qa.size() - (acc_a ? 1 : 0);
         if (held > 0) exp_r = qa[0];
      end else begin
         tag       = "B";
         v         = b_valid_out;
         r         = b_ready_out;
         ri        = b_ready_in;
         act.data  = b_way_out;
         act.index = 6'(b_index);
         act.hit   = b_hit;
         act.multi = b_multi;
         held      = qb.size() - (acc_b ? 1 : 0);
         if (held > 0) exp_r = qb[0];
      end
      checkValue({tag, " valid_out"}, 64'(v), 64'(held > 0));
      checkValue({tag, " ready_out"}, 64'(r), 64'(!post_reset && (held < 2)));
      checkValue({tag, " result{data,index,hit,multi}"}, 64'(act), 64'(exp_r));
      if (v && ri && (held > 0)) begin
         if (lane == 0) void'(qa.pop_front());
         else           void'(qb.pop_front());
      end
   endtask

   // Monitor: sample mid-cycle, well away from the rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         checkValue("A valid_out in reset", 64'(a_valid_out), 64'd0);
         checkValue("A ready_out in reset", 64'(a_ready_out), 64'd0);
         checkValue("A outputs in reset", 64'({a_way_out, a_index, a_hit, a_multi}), 64'd0);
         checkValue("B valid_out in reset", 64'(b_valid_out), 64'd0);
         checkValue("B ready_out in reset", 64'(b_ready_out), 64'd0);
         checkValue("B outputs in reset", 64'({b_way_out, b_index, b_hit, b_multi}), 64'd0);
         qa.delete();
         qb.delete();
         post_reset = 1'b1;
      end else begin
         checkOutput(0);
         checkOutput(1);
         post_reset = 1'b0;
         if (done) begin
            checkValue("A accept timeout", 64'(stall_timeout), 64'd0);
            checkValue("A results drained", 64'(qa.size()), 64'd0);
            checkValue("B results drained", 64'(qb.size()), 64'd0);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
         end
      end
   end

   initial begin
      logic         ga;
      logic         gb;
      logic [63:0]  sa;
      logic [63:0]  sb;
      logic [159:0] db;
      int           tries;

      vectors       = 0;
      miscompares   = 0;
      post_reset    = 1'b0;
      done          = 1'b0;
      stall_timeout = 1'b0;
      acc_a         = 1'b0;
      acc_b         = 1'b0;
      rst_n         = 1'b1;
      a_valid_in    = 1'b0;
      a_sel         = '0;
      a_way_in      = '0;
      a_ready_in    = 1'b0;
      b_valid_in    = 1'b0;
      b_sel         = '0;
      b_way_in      = '0;
      b_ready_in    = 1'b0;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] directed selection vectors");
      // way 2 holds A, single hit
      applyStimulus(1'b1, 8'b0000_0100, 32'h7654_3A10, 1'b1, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      // ways 7, 4, 0 hit: way 7 (C) wins, multi-hit
      applyStimulus(1'b1, 8'b1001_0001, 32'hC654_3A10, 1'b1, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      // no hit: result all zero but still valid
      applyStimulus(1'b1, 8'b0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      applyStimulus(1'b0, 8'b0000_0000, 32'h0, 1'b1, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      applyStimulus(1'b0, 8'b0000_0000, 32'h0, 1'b1, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);

      $display("[TB] back-pressure with three back-to-back inputs");
      applyStimulus(1'b1, 8'h01, 32'h1111_1115, 1'b0, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      applyStimulus(1'b1, 8'h80, 32'h9222_2222, 1'b0, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      applyStimulus(1'b1, 8'h24, 32'h33B3_3333, 1'b0, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      applyStimulus(1'b1, 8'h24, 32'h33B3_3333, 1'b0, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      ga    = 1'b0;
      tries = 0;
      while (!ga && (tries < 8)) begin
         applyStimulus(1'b1, 8'h24, 32'h33B3_3333, 1'b1, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
         tries++;
      end
      if (!ga) stall_timeout = 1'b1;
      repeat (4) applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);

      $display("[TB] randomized traffic with back-pressure");
      for (int c = 0; c < 10000; c++) begin
         sa = randSel(A_WAYS);
         sb = randSel(B_WAYS);
         for (int i = 0; i < B_WAYS; i++) db[i*32 +: 32] = $urandom();
         applyStimulus($urandom_range(0, 3) != 0, sa[7:0], $urandom(), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3) != 0, sb[4:0], db, $urandom_range(0, 2) != 0, ga, gb);
      end

      $display("[TB] reset while buffer is full");
      repeat (4) applyStimulus(1'b1, 8'h10, 32'h000A_0000, 1'b0, 1'b1, 5'h01, 160'h5, 1'b0, ga, gb);
      doReset(2);
      applyStimulus(1'b1, 8'h02, 32'h0000_00D0, 1'b1, 1'b1, 5'h18, {32'hDEAD_BEEF, 128'd7}, 1'b1, ga, gb);
      applyStimulus(1'b1, 8'h06, 32'h0000_0E70, 1'b1, 1'b0, 5'h00, 160'd0, 1'b1, ga, gb);
      repeat (10) applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 5'd0, 160'd0, 1'b1, ga, gb);
      done = 1'b1;
   end

endmodule
